// File: rtl/fls_seq.sv
// rtl/fls_seq.sv - Fibonacci-like sequence driver/consumer for the lab ALU
//
// Loads two seed terms from d, then produces each later term as the ALU sum
// of the two previous terms. One step per 0->1 transition of en.
//
// Parameters:
//   WIDTH   datapath width; must match the attached ALU
// Ports:
//   clk     system clock, rising edge
//   rst_n   synchronous active-low reset
//   en      step request (level, rising-edge detected)
//   d       seed term, sampled on the first two steps only
//   alu_y   ALU result (combinational, same cycle)
//   alu_cf  ALU carry flag for the current operands
//   alu_a   ALU operand a = older term
//   alu_b   ALU operand b = newer term
//   alu_m   ALU opcode, constant ADD (3'b000)
//   f       most recent term
//   upd     one-cycle pulse the cycle after a step
//   carry   sticky unsigned-wrap flag
//   cnt     8-bit saturating step counter (only with FLS_CNT_EN)
// Build option: define FLS_CNT_EN to add the cnt output and its counter.

module fls_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cf,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_m,
  output logic [WIDTH-1:0] f,
  output logic             upd,
  output logic             carry
`ifdef FLS_CNT_EN
  ,
  output logic [7:0]       cnt
`endif
);

  typedef enum logic [1:0] {
    S_LOAD0 = 2'b00,
    S_LOAD1 = 2'b01,
    S_RUN   = 2'b10,
    S_BAD   = 2'b11
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] r0;
  logic [WIDTH-1:0] r1;
  logic             en_q;
  logic             step;

  assign step = en & ~en_q;

  // ALU operands come from registers only, so there is no loop through the ALU.
  assign alu_a = r0;
  assign alu_b = r1;
  assign alu_m = 3'b000;
  assign f     = r1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_LOAD0;
      r0    <= '0;
      r1    <= '0;
      // Reset treats en as already high so a held button is not a press.
      en_q  <= 1'b1;
      upd   <= 1'b0;
      carry <= 1'b0;
    end else begin
      en_q <= en;
      upd  <= step;
      case (state)
        S_LOAD0: begin
          if (step) begin
            r1    <= d;
            state <= S_LOAD1;
          end
        end
        S_LOAD1: begin
          if (step) begin
            r0    <= r1;
            r1    <= d;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (step) begin
            r0    <= r1;
            r1    <= alu_y;
            carry <= carry | alu_cf;
          end
        end
        S_BAD: begin
          state <= S_LOAD0;
        end
      endcase
    end
  end

`ifdef FLS_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (step && (cnt != 8'hFF)) begin
      cnt <= cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fls_seq.sv
// tb/tb_fls_seq.sv - self-checking bench for fls_seq (32-bit and 8-bit instances)

module tb_fls_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] d32 = '0;
  logic [7:0]  d8 = '0;

  logic [31:0] a32, b32, f32, y32;
  logic [2:0]  m32;
  logic        upd32, carry32, cf32;
  logic [7:0]  a8, b8, f8, y8;
  logic [2:0]  m8;
  logic        upd8, carry8, cf8;
`ifdef FLS_CNT_EN
  logic [7:0]  cnt32, cnt8;
`endif

  always #5 clk = ~clk;

  // Combinational ALU models, ADD only.
  assign {cf32, y32} = {1'b0, a32} + {1'b0, b32};
  assign {cf8, y8}   = {1'b0, a8} + {1'b0, b8};

  fls_seq #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d32), .alu_y(y32), .alu_cf(cf32),
    .alu_a(a32), .alu_b(b32), .alu_m(m32), .f(f32), .upd(upd32), .carry(carry32)
`ifdef FLS_CNT_EN
    , .cnt(cnt32)
`endif
  );

  fls_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d8), .alu_y(y8), .alu_cf(cf8),
    .alu_a(a8), .alu_b(b8), .alu_m(m8), .f(f8), .upd(upd8), .carry(carry8)
`ifdef FLS_CNT_EN
    , .cnt(cnt8)
`endif
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Reference model: the whole sequence since the last reset, as a list.
  logic [31:0] t32 [0:2047];
  logic [7:0]  t8  [0:2047];
  int          n = 0;
  bit          wrap32 = 0, wrap8 = 0;
  bit          en_prev = 1;
  bit          upd_m = 0;
  bit          started = 0;

  always @(posedge clk) begin : model
    logic [32:0] s33;
    logic [8:0]  s9;
    bit          press;
    if (!rst_n) begin
      n       = 0;
      wrap32  = 0;
      wrap8   = 0;
      en_prev = 1;
      upd_m   = 0;
      started = 1;
    end else begin
      press   = en && !en_prev;
      en_prev = en;
      upd_m   = press;
      if (press) begin
        if (n < 2) begin
          t32[n] = d32;
          t8[n]  = d8;
        end else begin
          s33 = 33'(t32[n-1]) + 33'(t32[n-2]);
          s9  = 9'(t8[n-1]) + 9'(t8[n-2]);
          t32[n] = s33[31:0];
          t8[n]  = s9[7:0];
          if (s33[32]) wrap32 = 1;
          if (s9[8])   wrap8  = 1;
        end
        n = n + 1;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] ef32, ea32;
    logic [7:0]  ef8, ea8;
    if (started) begin
      ef32 = 0; ea32 = 0; ef8 = 0; ea8 = 0;
      if (n >= 1) begin ef32 = t32[n-1]; ef8 = t8[n-1]; end
      if (n >= 2) begin ea32 = t32[n-2]; ea8 = t8[n-2]; end
      chk("f32", 64'(f32), 64'(ef32));
      chk("alu_a32", 64'(a32), 64'(ea32));
      chk("alu_b32", 64'(b32), 64'(ef32));
      chk("alu_m32", 64'(m32), 64'd0);
      chk("upd32", 64'(upd32), 64'(upd_m));
      chk("carry32", 64'(carry32), 64'(wrap32));
      chk("f8", 64'(f8), 64'(ef8));
      chk("alu_a8", 64'(a8), 64'(ea8));
      chk("alu_m8", 64'(m8), 64'd0);
      chk("upd8", 64'(upd8), 64'(upd_m));
      chk("carry8", 64'(carry8), 64'(wrap8));
`ifdef FLS_CNT_EN
      chk("cnt32", 64'(cnt32), 64'((n > 255) ? 255 : n));
      chk("cnt8", 64'(cnt8), 64'((n > 255) ? 255 : n));
`endif
    end
  end

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [31:0] v32, input logic [7:0] v8);
    d32 = v32;
    d8  = v8;
    en  = 1'b1;
    cyc(1);
    en  = 1'b0;
    cyc(1);
  endtask

  task automatic do_reset;
    en    = 1'b0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("reset_f", 64'(f32), 64'd0);
    chk("reset_upd", 64'(upd32), 64'd0);

    // Basic sequence: 1, 1, 2, 3, 5, 8 with d=99 ignored after loading
    press(1, 1);
    chk("basic_f1", 64'(f32), 64'd1);
    press(1, 1);
    for (int i = 0; i < 3; i++) press(99, 99);
    chk("basic_a_before6", 64'(a32), 64'd3);
    chk("basic_b_before6", 64'(b32), 64'd5);
    press(99, 99);
    chk("basic_f6", 64'(f32), 64'd8);
    chk("basic_carry", 64'(carry32), 64'd0);
    chk("model_t5", 64'(t32[5]), 64'd8);

    // Held button: one step only, then one more on re-press
    do_reset();
    d32 = 7; d8 = 7; en = 1'b1;
    cyc(20);
    chk("held_f", 64'(f32), 64'd7);
    en = 1'b0;
    cyc(1);
    press(9, 9);
    chk("held_f2", 64'(f32), 64'd9);
    chk("held_a2", 64'(a32), 64'd7);

    // Wrap on the 8-bit instance: 200 + 100 = 44 with carry, then 144
    do_reset();
    press(200, 200);
    press(100, 100);
    press(0, 0);
    chk("wrap_f44", 64'(f8), 64'd44);
    chk("wrap_c1", 64'(carry8), 64'd1);
    press(0, 0);
    chk("wrap_f144", 64'(f8), 64'd144);
    chk("wrap_c_sticky", 64'(carry8), 64'd1);

    // Reset mid-run with en rising in the reset cycle
    do_reset();
    press(1, 1);
    press(1, 1);
    for (int i = 0; i < 5; i++) press(0, 0);
    chk("mid_f13", 64'(f32), 64'd13);
    rst_n = 1'b0;
    en    = 1'b1;
    cyc(1);
    rst_n = 1'b1;
    chk("mid_rst_f", 64'(f32), 64'd0);
    chk("mid_rst_upd", 64'(upd32), 64'd0);
    chk("mid_rst_carry", 64'(carry8), 64'd0);
    cyc(2);
    en = 1'b0;
    cyc(1);
    press(5, 5);
    chk("mid_reload", 64'(f32), 64'd5);

    // en held high through reset and after: no step
    en    = 1'b1;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    chk("en_hold_f", 64'(f32), 64'd0);
    en = 1'b0;
    cyc(1);

    // Randomised run with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) rst_n = 1'b0;
      else rst_n = 1'b1;
      en  = 1'($urandom_range(0, 1));
      d32 = $urandom;
      d8  = 8'($urandom);
      cyc(1);
    end
    rst_n = 1'b1;

    // Long run: counter saturation (when built in) while the sequence continues
    do_reset();
    for (int i = 0; i < 300; i++) press($urandom, 8'($urandom));
`ifdef FLS_CNT_EN
    chk("cnt_sat", 64'(cnt32), 64'd255);
    do_reset();
    chk("cnt_reset", 64'(cnt32), 64'd0);
`endif
    cyc(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
